controle_multiciclo: RTL

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle processor control unit: fetch/decode/execute/memory/writeback FSM.
// Control strobes are decoded from the current state, the latched opcode, zero and mem_ready.
module controle_multiciclo #(
  parameter int unsigned OPW = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           EscIR,
  output logic           EscPC,
  output logic [1:0]     PCFonte,
  output logic           IouD,
  output logic           LerMEM,
  output logic           EscMEM,
  output logic           EscReg,
  output logic           RegFonte,
  output logic           FonteEscReg,
  output logic [1:0]     ULAOp,
  output logic [1:0]     ULAFonte,
  output logic [2:0]     estado,
  output logic           busy,
  output logic           halted,
  output logic [15:0]    instr_count
);

  localparam int unsigned CNT_W = 16;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(3'b000);
  localparam logic [OPW-1:0] OP_COPY  = OPW'(3'b001);
  localparam logic [OPW-1:0] OP_READ  = OPW'(3'b010);
  localparam logic [OPW-1:0] OP_WRITE = OPW'(3'b011);
  localparam logic [OPW-1:0] OP_BEQZ  = OPW'(3'b100);
  localparam logic [OPW-1:0] OP_JUMP  = OPW'(3'b101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(3'b110);
  localparam logic [OPW-1:0] OP_STOP  = OPW'(3'b111);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSCA = 3'd1,
    DECOD = 3'd2,
    EXEC  = 3'd3,
    MEM   = 3'd4,
    ESCR  = 3'd5,
    HALT  = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [CNT_W-1:0] cnt_q;

  // State, opcode latch and saturating decoded-instruction counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECOD) begin
        op_q <= opcode;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = BUSCA;
      BUSCA: if (mem_ready) state_d = DECOD;
      DECOD: begin
        if (opcode == OP_STOP)      state_d = HALT;
        else if (opcode == OP_JUMP) state_d = BUSCA;
        else                        state_d = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_ADD, OP_COPY, OP_ADDI: state_d = ESCR;
          OP_READ, OP_WRITE:        state_d = MEM;
          default:                  state_d = BUSCA;
        endcase
      end
      MEM: if (mem_ready) state_d = (op_q == OP_READ) ? ESCR : BUSCA;
      ESCR:  state_d = BUSCA;
      HALT:  state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes; the JUMP PC load in DECOD uses the freshly loaded IR field
  always_comb begin
    EscIR       = 1'b0;
    EscPC       = 1'b0;
    PCFonte     = 2'b00;
    IouD        = 1'b0;
    LerMEM      = 1'b0;
    EscMEM      = 1'b0;
    EscReg      = 1'b0;
    RegFonte    = 1'b0;
    FonteEscReg = 1'b0;
    ULAOp       = 2'b00;
    ULAFonte    = 2'b10;
    case (state_q)
      BUSCA: begin
        LerMEM = 1'b1;
        if (mem_ready) begin
          EscIR = 1'b1;
          EscPC = 1'b1;
        end
      end
      DECOD: begin
        if (opcode == OP_JUMP) begin
          EscPC   = 1'b1;
          PCFonte = 2'b10;
        end
      end
      EXEC: begin
        if (op_q == OP_BEQZ && zero) begin
          EscPC   = 1'b1;
          PCFonte = 2'b01;
        end
      end
      MEM: begin
        IouD   = 1'b1;
        LerMEM = (op_q == OP_READ);
        EscMEM = (op_q == OP_WRITE);
      end
      ESCR: begin
        EscReg      = 1'b1;
        RegFonte    = (op_q == OP_READ);
        FonteEscReg = (op_q == OP_ADDI);
      end
      default: ;
    endcase
    if (state_q == EXEC || state_q == MEM || state_q == ESCR) begin
      case (op_q)
        OP_COPY:           ULAFonte = 2'b01;
        OP_READ, OP_WRITE,
        OP_ADDI:           ULAFonte = 2'b00;
        OP_BEQZ: begin
          ULAOp    = 2'b01;
          ULAFonte = 2'b01;
        end
        default:           ULAFonte = 2'b10;
      endcase
    end
  end

  assign estado      = state_q;
  assign busy        = (state_q != IDLE) && (state_q != HALT);
  assign halted      = (state_q == HALT);
  assign instr_count = cnt_q;

endmodule
